neo_pixel_receiver: RTL

- Decodes a WS2812-style single-wire NeoPixel serial stream back into per-pixel 24-bit GRB words. It is the receive end of the strand controller's `neo_data` line.
- Used for loopback checking on GPIO and as a bench monitor for the strand controller.
- Measures each high pulse width to classify it as 0 or 1, and assembles 24 bits per pixel, MSB first.
- Tracks pixel index within a frame and detects the latch gap that ends a frame.

---
 rtl/neo_pkg.sv | 40 ++++
 rtl/neo_bit_decoder.sv | 125 ++++++++++++
 rtl/neo_pixel_receiver.sv | 114 +++++++++++
 3 files changed

// File: rtl/neo_pkg.sv
// Shared constants and types for the NeoPixel receive path.
// Timing constants assume a 50 MHz clock.
package neo_pkg;

  localparam int T0H_CYCLES        = 18;
  localparam int T1H_CYCLES        = 35;
  localparam int BIT_PERIOD_CYCLES = 62;
  localparam int RESET_CYCLES      = 2500;
  localparam int PIXEL_BITS        = 24;

  typedef struct packed {
    logic [7:0] green;
    logic [7:0] red;
    logic [7:0] blue;
  } pixel_t;

  typedef enum logic [1:0] {
    GREEN,
    RED,
    BLUE
  } color_e;

  typedef enum logic [1:0] {
    ST_WAIT_GAP,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } rx_state_e;

  function automatic logic [7:0] color_byte(input pixel_t p, input color_e c);
    logic [7:0] b;
    case (c)
      GREEN:   b = p.green;
      RED:     b = p.red;
      default: b = p.blue;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/neo_bit_decoder.sv
// Pulse-width classifier and latch-gap detector for a WS2812-style line.
// Define NEO_RX_SYNC_EN to pass neo_data through a two-flop synchronizer first.
module neo_bit_decoder
  import neo_pkg::*;
#(
  parameter int BIT_THRESHOLD = 26,
  parameter int MIN_HIGH      = 8,
  parameter int MAX_HIGH      = 50,
  parameter int RESET_CYCLES  = 2500
) (
  input  logic clock,
  input  logic reset,
  input  logic neo_data,
  output logic bit_valid,
  output logic bit_value,
  output logic gap,
  output logic glitch,
  output logic stuck
);

  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_CYCLES + 1);

  localparam logic [HW-1:0] HIGH_MIN = HW'(MIN_HIGH);
  localparam logic [HW-1:0] HIGH_MAX = HW'(MAX_HIGH);
  localparam logic [HW-1:0] HIGH_SAT = HW'(MAX_HIGH + 1);
  localparam logic [HW-1:0] HIGH_ONE = HW'(BIT_THRESHOLD);
  localparam logic [LW-1:0] LOW_LAST = LW'(RESET_CYCLES - 1);
  localparam logic [LW-1:0] LOW_SAT  = LW'(RESET_CYCLES);

  logic d;
  logic d_reg;

`ifdef NEO_RX_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], neo_data};
    end
  end

  assign d = sync_reg[1];
`else
  assign d = neo_data;
`endif

  logic rise;
  logic fall;

  assign rise = d & ~d_reg;
  assign fall = ~d & d_reg;

  rx_state_e       state_reg;
  logic [HW-1:0]   high_cnt_reg;
  logic [LW-1:0]   low_cnt_reg;

  // Events are decoded from the current sample so the top can register its
  // outputs on the very edge that completes a bit or a gap.
  assign stuck     = (state_reg == ST_HIGH) && d && (high_cnt_reg >= HIGH_MAX);
  assign glitch    = (state_reg == ST_HIGH) && fall && (high_cnt_reg < HIGH_MIN);
  assign bit_valid = (state_reg == ST_HIGH) && fall && (high_cnt_reg >= HIGH_MIN);
  assign bit_value = (high_cnt_reg >= HIGH_ONE);
  assign gap       = (state_reg == ST_LOW) && !d && (low_cnt_reg >= LOW_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_WAIT_GAP;
      d_reg        <= 1'b0;
      high_cnt_reg <= '0;
      low_cnt_reg  <= '0;
    end else begin
      d_reg <= d;
      case (state_reg)
        ST_WAIT_GAP: begin
          if (d) begin
            low_cnt_reg <= '0;
          end else if (low_cnt_reg >= LOW_LAST) begin
            state_reg   <= ST_IDLE;
            low_cnt_reg <= '0;
          end else begin
            low_cnt_reg <= low_cnt_reg + 1'b1;
          end
        end
        ST_IDLE: begin
          if (rise) begin
            state_reg    <= ST_HIGH;
            high_cnt_reg <= HW'(1);
          end
        end
        ST_HIGH: begin
          if (stuck) begin
            state_reg    <= ST_WAIT_GAP;
            high_cnt_reg <= HIGH_SAT;
            low_cnt_reg  <= '0;
          end else if (fall) begin
            // The falling-edge sample is already the first low cycle.
            state_reg   <= glitch ? ST_WAIT_GAP : ST_LOW;
            low_cnt_reg <= LW'(1);
          end else if (high_cnt_reg < HIGH_SAT) begin
            high_cnt_reg <= high_cnt_reg + 1'b1;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state_reg    <= ST_HIGH;
            high_cnt_reg <= HW'(1);
            low_cnt_reg  <= '0;
          end else if (gap) begin
            state_reg   <= ST_IDLE;
            low_cnt_reg <= '0;
          end else if (low_cnt_reg < LOW_SAT) begin
            low_cnt_reg <= low_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_WAIT_GAP;
        end
      endcase
    end
  end

endmodule

// File: rtl/neo_pixel_receiver.sv
// Assembles decoded NeoPixel bits into 24-bit GRB pixels and frames.
// Optional NEO_RX_SYNC_EN adds a two-flop input synchronizer in the decoder.
module neo_pixel_receiver
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS    = 5,
  parameter int BIT_THRESHOLD = 26,
  parameter int MIN_HIGH      = 8,
  parameter int MAX_HIGH      = 50,
  parameter int RESET_CYCLES  = neo_pkg::RESET_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        neo_data,
  output logic [23:0] pixel_data,
  output logic [2:0]  pixel_index,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic        error
);

  localparam logic [2:0] PIX_LIMIT = 3'(NUM_PIXELS);
  localparam logic [4:0] LAST_BIT  = 5'(PIXEL_BITS - 1);

  logic bit_valid;
  logic bit_value;
  logic gap;
  logic glitch;
  logic stuck;

  neo_bit_decoder #(
    .BIT_THRESHOLD(BIT_THRESHOLD),
    .MIN_HIGH     (MIN_HIGH),
    .MAX_HIGH     (MAX_HIGH),
    .RESET_CYCLES (RESET_CYCLES)
  ) u_bit_decoder (
    .clock    (clock),
    .reset    (reset),
    .neo_data (neo_data),
    .bit_valid(bit_valid),
    .bit_value(bit_value),
    .gap      (gap),
    .glitch   (glitch),
    .stuck    (stuck)
  );

  logic [23:0] shift_reg;
  logic [23:0] shift_next;
  logic [4:0]  bit_cnt_reg;
  logic [2:0]  pixel_cnt_reg;
  logic        drop_reg;
  pixel_t      pixel_data_reg;
  logic [2:0]  pixel_index_reg;
  logic        pixel_valid_reg;
  logic        frame_done_reg;
  logic        error_reg;

  assign shift_next = {shift_reg[22:0], bit_value};

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      pixel_cnt_reg   <= '0;
      drop_reg        <= 1'b0;
      pixel_data_reg  <= '0;
      pixel_index_reg <= '0;
      pixel_valid_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      pixel_valid_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      error_reg       <= 1'b0;
      if (glitch || stuck) begin
        // The decoder now waits for a fresh gap; nothing of this frame survives.
        error_reg     <= 1'b1;
        bit_cnt_reg   <= '0;
        pixel_cnt_reg <= '0;
        drop_reg      <= 1'b0;
      end else if (gap) begin
        frame_done_reg <= (pixel_cnt_reg != 3'd0);
        error_reg      <= (bit_cnt_reg != 5'd0);
        bit_cnt_reg    <= '0;
        pixel_cnt_reg  <= '0;
        drop_reg       <= 1'b0;
      end else if (bit_valid && !drop_reg) begin
        shift_reg <= shift_next;
        if (bit_cnt_reg == LAST_BIT) begin
          bit_cnt_reg <= '0;
          if (pixel_cnt_reg >= PIX_LIMIT) begin
            // Overflow pixel: report once, then ignore the rest of the frame.
            error_reg <= 1'b1;
            drop_reg  <= 1'b1;
          end else begin
            pixel_valid_reg <= 1'b1;
            pixel_data_reg  <= pixel_t'(shift_next);
            pixel_index_reg <= pixel_cnt_reg;
            pixel_cnt_reg   <= pixel_cnt_reg + 3'd1;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
        end
      end
    end
  end

  assign pixel_data  = pixel_data_reg;
  assign pixel_index = pixel_index_reg;
  assign pixel_valid = pixel_valid_reg;
  assign frame_done  = frame_done_reg;
  assign error       = error_reg;

endmodule
